// File: rtl/spi_master.sv
// SPI master: turns an accepted parallel word into one cs_n-framed transfer
// and returns the received word on a single-cycle rx_valid pulse.
module spi_master #(
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DIV_W-1:0]        r_div_cnt, w_div_nxt;
  logic [EDGE_W-1:0]       r_edge_cnt, w_edge_nxt;
  logic [DATA_WIDTH-1:0]   r_tx_shift, w_tx_nxt;
  logic [DATA_WIDTH-1:0]   r_rx_shift, w_rx_nxt;
  logic [DATA_WIDTH-1:0]   r_rx_data, w_rx_data_nxt;
  logic                    r_sclk, w_sclk_nxt;
  logic                    r_cs_n, w_cs_n_nxt;
  logic                    r_mosi, w_mosi_nxt;
  logic                    r_rx_valid, w_rx_valid_nxt;
  logic                    w_div_done;
  logic                    w_leading;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
  endfunction

  // LSB-first mode shifts in at the top so the first received bit ends in bit 0.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                     input logic b);
    return MSB_FIRST ? {v[DATA_WIDTH-2:0], b} : {b, v[DATA_WIDTH-1:1]};
  endfunction

  assign w_div_done = (r_div_cnt == DIV_LAST);
  assign w_leading  = ~r_edge_cnt[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_edge_cnt <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_sclk     <= CPOL;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      r_state    <= w_state_nxt;
      r_div_cnt  <= w_div_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_tx_shift <= w_tx_nxt;
      r_rx_shift <= w_rx_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_sclk     <= w_sclk_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_mosi     <= w_mosi_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    w_state_nxt    = r_state;
    w_div_nxt      = r_div_cnt;
    w_edge_nxt     = r_edge_cnt;
    w_tx_nxt       = r_tx_shift;
    w_rx_nxt       = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_sclk_nxt     = r_sclk;
    w_cs_n_nxt     = r_cs_n;
    w_mosi_nxt     = r_mosi;
    w_rx_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_div_nxt  = '0;
        w_edge_nxt = '0;
        if (tx_valid) begin
          w_state_nxt = S_SETUP;
          w_cs_n_nxt  = 1'b0;
          w_rx_nxt    = '0;
          if (CPHA) begin
            w_tx_nxt   = tx_data;
            w_mosi_nxt = 1'b0;
          end else begin
            w_tx_nxt   = shift_out(tx_data);
            w_mosi_nxt = first_bit(tx_data);
          end
        end
      end

      S_SETUP: begin
        if (w_div_done) begin
          w_div_nxt   = '0;
          w_state_nxt = S_XFER;
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_XFER: begin
        if (w_div_done) begin
          w_div_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          w_edge_nxt = r_edge_cnt + EDGE_W'(1);
          // Capture edge is leading for CPHA=0, trailing for CPHA=1; drive is the other one.
          if (w_leading != CPHA)
            w_rx_nxt = shift_in(r_rx_shift, miso);
          if ((w_leading == CPHA) && (r_edge_cnt != EDGE_LAST)) begin
            w_mosi_nxt = first_bit(r_tx_shift);
            w_tx_nxt   = shift_out(r_tx_shift);
          end
          if (r_edge_cnt == EDGE_LAST)
            w_state_nxt = S_HOLD;
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (w_div_done) begin
          w_div_nxt      = '0;
          w_state_nxt    = S_GAP;
          w_cs_n_nxt     = 1'b1;
          w_mosi_nxt     = 1'b0;
          w_rx_valid_nxt = 1'b1;
          w_rx_data_nxt  = r_rx_shift;
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (w_div_done) begin
          w_div_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign sclk     = r_sclk;
  assign cs_n     = r_cs_n;
  assign mosi     = r_mosi;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances in different SPI modes, driven frame
// by frame against a bit-level slave model and frame-level expectations.
module tb_spi_master;

  localparam int DW = 8;
  localparam int N  = 3;
  // Instance 0: mode 0, MSB first, div 2. Instance 1: mode 3, LSB first, div 2.
  // Instance 2: mode 2, MSB first, div 1.
  localparam bit [N-1:0] CPOL_V = 3'b110;
  localparam bit [N-1:0] CPHA_V = 3'b010;
  localparam bit [N-1:0] MSB_V  = 3'b101;
  localparam int         DIV_V [N] = '{2, 2, 1};

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  tv;
  logic [DW-1:0] td;
  logic [N-1:0]  miso_v;
  logic [N-1:0]  ready_v, rxv_v, busy_v, sclk_v, csn_v, mosi_v;
  logic [DW-1:0] rxd0, rxd1, rxd2, m_rxd;
  int            sel;
  int            checks = 0;
  int            errors = 0;
  int unsigned   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master #(.CPOL(CPOL_V[0]), .CPHA(CPHA_V[0]), .DATA_WIDTH(DW), .MSB_FIRST(MSB_V[0]),
               .CLK_DIV(2)) u_m0 (
    .clk(clk), .reset(reset), .tx_valid(tv[0]), .tx_ready(ready_v[0]), .tx_data(td),
    .rx_valid(rxv_v[0]), .rx_data(rxd0), .busy(busy_v[0]), .sclk(sclk_v[0]),
    .cs_n(csn_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]));

  spi_master #(.CPOL(CPOL_V[1]), .CPHA(CPHA_V[1]), .DATA_WIDTH(DW), .MSB_FIRST(MSB_V[1]),
               .CLK_DIV(2)) u_m3 (
    .clk(clk), .reset(reset), .tx_valid(tv[1]), .tx_ready(ready_v[1]), .tx_data(td),
    .rx_valid(rxv_v[1]), .rx_data(rxd1), .busy(busy_v[1]), .sclk(sclk_v[1]),
    .cs_n(csn_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]));

  spi_master #(.CPOL(CPOL_V[2]), .CPHA(CPHA_V[2]), .DATA_WIDTH(DW), .MSB_FIRST(MSB_V[2]),
               .CLK_DIV(1)) u_d1 (
    .clk(clk), .reset(reset), .tx_valid(tv[2]), .tx_ready(ready_v[2]), .tx_data(td),
    .rx_valid(rxv_v[2]), .rx_data(rxd2), .busy(busy_v[2]), .sclk(sclk_v[2]),
    .cs_n(csn_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2]));

  always_comb begin
    case (sel)
      0:       m_rxd = rxd0;
      1:       m_rxd = rxd1;
      default: m_rxd = rxd2;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit j of a word on the wire, in the configured bit order.
  function automatic logic wire_bit(input logic [DW-1:0] w, input int j, input bit msb);
    logic [DW-1:0] t;
    t = w;
    return msb ? t[DW-1-j] : t[j];
  endfunction

  // One frame on instance sel. Outputs are sampled on negedges; the slave
  // model updates miso right after each of its shift edges.
  task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] sw, input bit keep,
                           input logic [DW-1:0] next_td, input int abort_at,
                           output int unsigned t_fall, output int unsigned t_rise);
    bit cpol, cpha, msb, leading, pre_ok, ready_bad, rx_early, prev;
    int d, low, tog, ns, budget, gap, extra;
    logic [DW-1:0] got;
    cpol = CPOL_V[sel]; cpha = CPHA_V[sel]; msb = MSB_V[sel]; d = DIV_V[sel];
    t_fall = 0; t_rise = 0;
    check("ready_idle", ready_v[sel], 1);
    check("sclk_idle", sclk_v[sel], cpol);
    td = tx;
    tv[sel] = 1'b1;
    @(negedge clk);
    t_fall = cyc;
    tv[sel] = keep;
    td = next_td;
    check("cs_n_after_accept", csn_v[sel], 0);
    check("busy_after_accept", busy_v[sel], 1);
    check("ready_after_accept", ready_v[sel], 0);
    check("mosi_setup", mosi_v[sel], cpha ? 1'b0 : wire_bit(tx, 0, msb));
    if (!cpha) miso_v[sel] = wire_bit(sw, 0, msb);
    low = 1; tog = 0; ns = 0; got = '0; budget = 0;
    pre_ok = 1; ready_bad = 0; rx_early = 0; prev = sclk_v[sel];
    while (csn_v[sel] == 1'b0 && budget < 400) begin
      @(negedge clk);
      budget++;
      if (ready_v[sel]) ready_bad = 1;
      if (csn_v[sel] == 1'b0) begin
        low++;
        if (rxv_v[sel]) rx_early = 1;
        if (sclk_v[sel] != prev) begin
          tog++;
          prev = sclk_v[sel];
          leading = (tog % 2) == 1;
          if (tog == abort_at) begin
            reset = 1'b1;
            #1;
            check("abort_sclk", sclk_v[sel], cpol);
            check("abort_cs_n", csn_v[sel], 1);
            check("abort_mosi", mosi_v[sel], 0);
            check("abort_rx_valid", rxv_v[sel], 0);
            check("abort_busy", busy_v[sel], 0);
            return;
          end
          if (leading != cpha && ns < DW) begin
            got[msb ? DW-1-ns : ns] = mosi_v[sel];
            ns++;
          end
          if (leading == cpha && tog < 2*DW) miso_v[sel] = wire_bit(sw, tog/2, msb);
        end else if (cpha && tog == 0 && mosi_v[sel] !== 1'b0) begin
          pre_ok = 0;
        end
      end
    end
    t_rise = cyc;
    check("frame_done", csn_v[sel], 1);
    check("cs_n_low_cycles", low, d*(2*DW+2));
    check("sclk_toggles", tog, 2*DW);
    check("mosi_word", got, tx);
    if (cpha) check("mosi_zero_before_first_edge", pre_ok, 1);
    check("rx_valid_not_early", rx_early, 0);
    check("rx_valid_at_end", rxv_v[sel], 1);
    check("rx_data", m_rxd, sw);
    check("mosi_end", mosi_v[sel], 0);
    check("sclk_end", sclk_v[sel], cpol);
    gap = 0; extra = 0;
    while (!ready_v[sel] && gap < 50) begin
      @(negedge clk);
      gap++;
      if (rxv_v[sel]) extra++;
      if (csn_v[sel] !== 1'b1) ready_bad = 1;
    end
    check("gap_cycles", gap, d);
    check("rx_valid_single", extra, 0);
    check("ready_low_in_frame", ready_bad, 0);
    check("rx_data_holds", m_rxd, sw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned tf1, tr1, tf2, tr2;
    reset = 1'b1; tv = '0; td = '0; miso_v = '0; sel = 0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", csn_v, 3'b111);
    check("rst_sclk", sclk_v, CPOL_V);
    check("rst_mosi", mosi_v, 0);
    check("rst_rx_valid", rxv_v, 0);
    check("rst_busy", busy_v, 0);
    check("rst_ready", ready_v, 3'b111);
    check("rst_rx_data", {rxd2, rxd1, rxd0}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Mode 0; tx_data drops to 0x00 right after accept and must be ignored.
    sel = 0; run_frame(8'hA5, 8'h3C, 0, 8'h00, 0, tf1, tr1);
    sel = 1; run_frame(8'h81, 8'h0F, 0, 8'($urandom), 0, tf1, tr1);
    sel = 2; run_frame(8'hFF, 8'($urandom), 0, 8'($urandom), 0, tf1, tr1);

    // Back-to-back with tx_valid held: cs_n stays high for the GAP plus the
    // IDLE cycle in which the pending request is accepted.
    for (int s = 0; s < N; s++) begin
      sel = s;
      run_frame(8'h11, 8'($urandom), 1, 8'h22, 0, tf1, tr1);
      run_frame(8'h22, 8'($urandom), 0, 8'($urandom), 0, tf2, tr2);
      check("b2b_cs_n_high", tf2 - tr1, DIV_V[s] + 1);
    end

    // Abort at the 5th sclk edge, then a fresh frame right after release.
    sel = 0;
    run_frame(8'h5A, 8'hC3, 0, 8'h00, 5, tf1, tr1);
    @(negedge clk);
    check("abort_no_rx_valid", rxv_v[0], 0);
    check("abort_rx_data_cleared", rxd0, 0);
    reset = 1'b0;
    run_frame(8'h96, 8'h69, 0, 8'($urandom), 0, tf1, tr1);

    for (int s = 0; s < N; s++) begin
      sel = s;
      for (int k = 0; k < 4; k++)
        run_frame(8'($urandom), 8'($urandom), 0, 8'($urandom), 0, tf1, tr1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
